mem_arbiter_rmw: RTL and testbench
==================================

# mem_arbiter_rmw

Parametrised arbiter between `NUM_PORTS` requesters (cartridge bus, USB, future DMA) and the single-port word memory controller. It replaces the fixed two-way cart/USB multiplexer. It adds:
- fixed or round-robin arbitration,
- per-byte write enables with automatic read-modify-write,
- configurable memory read latency.

Byte-lane steering and endianness swap stay in each requester; this block moves whole `DATA_W` words only.

## Interface
Parameters:
- `NUM_PORTS`, 2, number of requesters; port 0 = cart, port 1 = USB.
- `ADDR_W`, 17, memory word-address width.
- `DATA_W`, 32, memory word width; multiple of 8.
- `RD_LAT`, 1, cycles from the `mem_cmd`=READ cycle to valid `mem_rd_data`; range 1..7.
- `RR_MODE`, 1, arbitration mode: 1 = round-robin, 0 = fixed (lowest index wins).

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req_cmd` in 2*NUM_PORTS: per-port command; 00 idle, 01 read, 10 write, 11 treated as idle.
- `req_addr` in ADDR_W*NUM_PORTS: per-port word address.
- `req_wdata` in DATA_W*NUM_PORTS: per-port write data.
- `req_be` in (DATA_W/8)*NUM_PORTS: per-port byte enables; bit i covers data bits [8i+7:8i].
- `done` out NUM_PORTS: one-cycle completion pulse, one-hot.
- `rsp_rdata` out DATA_W: read data; valid only while `done` is high for a read.
- `grant` out NUM_PORTS: one-hot, the port currently being served.
- `mem_cmd` out 2: memory command; 00 idle, 01 read, 10 write.
- `mem_addr` out ADDR_W: memory word address.
- `mem_wr_data` out DATA_W: memory write data.
- `mem_rd_data` in DATA_W: memory read data.

## Operation
Requester rules:
- A requester holds `req_cmd`, `req_addr`, `req_wdata` and `req_be` stable until it sees `done`.
- It clears `req_cmd` on the same edge at which it samples `done`=1.

State machine states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE.

- **IDLE:** requests are sampled only here.
  - If no port requests, stay in IDLE.
  - Otherwise pick a winner. With `RR_MODE`=1, the winner is the first requesting port after `last_grant`, searching cyclically. With `RR_MODE`=0, the lowest requesting index wins.
  - Latch the winner's command, address, data and byte enables; set `grant`; update `last_grant`.
  - Next state:
    - read → RD_ISSUE.
    - write with `req_be` all ones → WR_ISSUE.
    - write with `req_be` partially set → RD_ISSUE.
    - write with `req_be` all zero → DONE, with no memory access.
- **RD_ISSUE:** `mem_cmd`=01 and `mem_addr`=latched address for exactly one cycle; then RD_WAIT.
- **RD_WAIT:** `mem_cmd`=00, `mem_addr` held. A down-counter loaded with `RD_LAT` runs here; `mem_rd_data` is captured on the edge ending the `RD_LAT`-th cycle.
  - Read: next state DONE.
  - Partial write: next state WR_ISSUE with merged data = (rd & ~mask) | (wdata & mask), where mask expands the byte enables to `DATA_W` bits.
- **WR_ISSUE:** `mem_cmd`=10, `mem_addr` = latched address, `mem_wr_data` = full or merged word, for one cycle; then DONE.
- **DONE:**
  - Outputs: `mem_cmd`=00, `mem_addr`=0, `mem_wr_data`=0; `done[winner]`=1; `rsp_rdata` = captured word for reads, 0 for writes.
  - Next state: IDLE, with `grant` cleared.
- In all states other than DONE, `done`=0 and `rsp_rdata`=0. `mem_wr_data` is 0 outside WR_ISSUE.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - All outputs 0: `mem_cmd`=00, `mem_addr`=0, `mem_wr_data`=0, `done`=0, `rsp_rdata`=0, `grant`=0.
  - `last_grant` = NUM_PORTS-1, so port 0 wins first in RR mode.
  - Reset mid-transaction abandons the access; no partial write is issued after reset.
- Latencies, counting cycle 0 as the IDLE cycle in which the request is sampled; DONE falls in cycle:
  - read: 2+RD_LAT.
  - full write: 2.
  - partial write: 3+RD_LAT.
  - empty-BE write: 1.
- One IDLE cycle always separates consecutive transactions. Back-to-back throughput for reads is one per 3+RD_LAT cycles.
- Requests arriving in non-IDLE states wait. A request withdrawn before it is granted is never served.
- Simultaneous requests from all ports in RR mode are served in cyclic order; no port waits longer than NUM_PORTS transactions.

## Test plan
- **Reset values:** assert `rst`=0 mid-RD_WAIT → all outputs 0 immediately; after release, port 0 read at 0x00010 → `mem_cmd`=01 in cycle 1, `done[0]` in cycle 3 with `RD_LAT`=1, `rsp_rdata` = memory word (e.g. 0xDEADBEEF).
- **Partial write:** memory[0x5]=0x11223344; port 1 writes 0xAABBCCDD with `req_be`=0010 → one read, then write 0x1122CC44; `done[1]` in cycle 4 (`RD_LAT`=1).
- **Full and empty writes:** full `req_be`=1111 → single WRITE in cycle 1, no READ, `done` in cycle 2. `req_be`=0000 → no `mem_cmd` activity, `done` in cycle 1.
- **Round-robin fairness:** ports 0 and 1 both hold reads continuously → grants alternate 0,1,0,1. With `RR_MODE`=0 → port 0 granted every time.
- **Latency parameter:** `RD_LAT`=3 model returns data 3 cycles after READ → correct word captured; `done` in cycle 5; words sampled one cycle early or late are never returned.
- **Illegal command:** `req_cmd`=11 on port 0 with port 1 idle → block stays in IDLE; `mem_cmd` remains 00.

Source files
------------

// File: rtl/mem_arbiter_rmw_if.sv
// Requester and memory-side signal bundle for mem_arbiter_rmw.
// The arbiter connects through the slave modport; requesters plus memory use master.
interface mem_arbiter_rmw_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 32
);
    logic [2*NUM_PORTS-1:0]          req_cmd;
    logic [ADDR_W*NUM_PORTS-1:0]     req_addr;
    logic [DATA_W*NUM_PORTS-1:0]     req_wdata;
    logic [(DATA_W/8)*NUM_PORTS-1:0] req_be;
    logic [NUM_PORTS-1:0]            done;
    logic [DATA_W-1:0]               rsp_rdata;
    logic [NUM_PORTS-1:0]            grant;
    logic [1:0]                      mem_cmd;
    logic [ADDR_W-1:0]               mem_addr;
    logic [DATA_W-1:0]               mem_wr_data;
    logic [DATA_W-1:0]               mem_rd_data;

    modport slave (
        input  req_cmd, req_addr, req_wdata, req_be, mem_rd_data,
        output done, rsp_rdata, grant, mem_cmd, mem_addr, mem_wr_data
    );

    modport master (
        output req_cmd, req_addr, req_wdata, req_be, mem_rd_data,
        input  done, rsp_rdata, grant, mem_cmd, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_arbiter_rmw.sv
// Arbiter between NUM_PORTS requesters and one single-port word memory,
// with fixed or round-robin selection and byte-enable read-modify-write.
module mem_arbiter_rmw #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter bit RR_MODE   = 1'b1
) (
    input logic clk,
    input logic rst,
    mem_arbiter_rmw_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [NUM_PORTS-1:0] PORT0_HOT = NUM_PORTS'(1);
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_DONE} state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_last;
    logic [NUM_PORTS-1:0] r_grant;
    logic [NUM_PORTS-1:0] r_done;
    logic [1:0]           r_mem_cmd;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wr_data;
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic                 r_is_wr;
    logic [2:0]           r_cnt;
    logic [DATA_W-1:0]    r_wdata;
    logic [BE_W-1:0]      r_be;

    logic [NUM_PORTS-1:0] w_req;
    logic                 w_any;
    logic [IDX_W-1:0]     w_win;
    int                   w_dist;
    int                   w_best;
    logic [1:0]           w_cmd;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_wdata;
    logic [BE_W-1:0]      w_be;

    function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < BE_W; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] rd,
                                                    input logic [DATA_W-1:0] wd,
                                                    input logic [BE_W-1:0]   be);
        return (rd & ~be_mask(be)) | (wd & be_mask(be));
    endfunction

    // Winner = requesting port with the smallest cyclic distance past r_last (RR) or lowest index.
    always_comb begin
        w_req  = '0;
        w_any  = 1'b0;
        w_win  = '0;
        w_dist = 0;
        w_best = NUM_PORTS;
        w_cmd  = CMD_IDLE;
        w_addr = '0;
        w_wdata = '0;
        w_be   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_req[p] = (bus.req_cmd[2*p +: 2] == CMD_RD) || (bus.req_cmd[2*p +: 2] == CMD_WR);
            w_dist = RR_MODE ? (p + 2*NUM_PORTS - int'(r_last) - 1) % NUM_PORTS : p;
            if (w_req[p] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = IDX_W'(p);
                w_any  = 1'b1;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (IDX_W'(p) == w_win) begin
                w_cmd   = bus.req_cmd[2*p +: 2];
                w_addr  = bus.req_addr[ADDR_W*p +: ADDR_W];
                w_wdata = bus.req_wdata[DATA_W*p +: DATA_W];
                w_be    = bus.req_be[BE_W*p +: BE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_last        <= IDX_W'(NUM_PORTS - 1);
            r_grant       <= '0;
            r_done        <= '0;
            r_mem_cmd     <= CMD_IDLE;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_rsp_rdata   <= '0;
            r_is_wr       <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= PORT0_HOT << w_win;
                        r_last  <= w_win;
                        r_is_wr <= (w_cmd == CMD_WR);
                        if (w_cmd == CMD_WR && w_be == '0) begin
                            r_done  <= PORT0_HOT << w_win;
                            r_state <= S_DONE;
                        end else if (w_cmd == CMD_WR && (&w_be)) begin
                            r_mem_cmd     <= CMD_WR;
                            r_mem_addr    <= w_addr;
                            r_mem_wr_data <= w_wdata;
                            r_state       <= S_WR_ISSUE;
                        end else begin
                            r_mem_cmd  <= CMD_RD;
                            r_mem_addr <= w_addr;
                            r_state    <= S_RD_ISSUE;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    r_mem_cmd <= CMD_IDLE;
                    r_cnt     <= 3'(RD_LAT);
                    r_state   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // Memory word is valid only in the last wait cycle.
                    if (r_cnt == 3'd1) begin
                        if (r_is_wr) begin
                            r_mem_cmd     <= CMD_WR;
                            r_mem_wr_data <= rmw_merge(bus.mem_rd_data, r_wdata, r_be);
                            r_state       <= S_WR_ISSUE;
                        end else begin
                            r_mem_addr  <= '0;
                            r_done      <= r_grant;
                            r_rsp_rdata <= bus.mem_rd_data;
                            r_state     <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_WR_ISSUE: begin
                    r_mem_cmd     <= CMD_IDLE;
                    r_mem_addr    <= '0;
                    r_mem_wr_data <= '0;
                    r_done        <= r_grant;
                    r_rsp_rdata   <= '0;
                    r_state       <= S_DONE;
                end
                S_DONE: begin
                    r_done      <= '0;
                    r_rsp_rdata <= '0;
                    r_grant     <= '0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write payload is captured only when a request is accepted; no reset needed.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_any) begin
            r_wdata <= w_wdata;
            r_be    <= w_be;
        end
    end

    assign bus.done        = r_done;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.grant       = r_grant;
    assign bus.mem_cmd     = r_mem_cmd;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wr_data = r_mem_wr_data;
endmodule

// File: tb/tb_mem_arbiter_rmw.sv
// Bench for mem_arbiter_rmw: two instances (RD_LAT=1 round-robin, RD_LAT=3 fixed)
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter_rmw;
    localparam int NP = 2;
    localparam int AW = 17;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2*NP-1:0]  t_cmd   = '0;
    logic [AW*NP-1:0] t_addr  = '0;
    logic [DW*NP-1:0] t_wdata = '0;
    logic [BW*NP-1:0] t_be    = '0;
    logic             sel     = 1'b0;

    mem_arbiter_rmw_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) if_a ();
    mem_arbiter_rmw_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) if_b ();

    mem_arbiter_rmw #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .RR_MODE(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    mem_arbiter_rmw #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .RR_MODE(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    assign if_a.req_cmd   = sel ? '0 : t_cmd;
    assign if_b.req_cmd   = sel ? t_cmd : '0;
    assign if_a.req_addr  = t_addr;
    assign if_b.req_addr  = t_addr;
    assign if_a.req_wdata = t_wdata;
    assign if_b.req_wdata = t_wdata;
    assign if_a.req_be    = t_be;
    assign if_b.req_be    = t_be;

    logic [1:0]    o_cmd;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wd, o_rsp;
    logic [NP-1:0] o_done, o_grant;
    assign o_cmd   = sel ? if_b.mem_cmd     : if_a.mem_cmd;
    assign o_addr  = sel ? if_b.mem_addr    : if_a.mem_addr;
    assign o_wd    = sel ? if_b.mem_wr_data : if_a.mem_wr_data;
    assign o_rsp   = sel ? if_b.rsp_rdata   : if_a.rsp_rdata;
    assign o_done  = sel ? if_b.done        : if_a.done;
    assign o_grant = sel ? if_b.grant       : if_a.grant;

    // Memory: 64 words, returns the word only in the cycle RD_LAT after READ, poison otherwise.
    function automatic logic [31:0] init_word(input logic [5:0] a);
        case (a)
            6'h10:   return 32'hDEADBEEF;
            6'h05:   return 32'h11223344;
            default: return {16'hC0DE, 10'd0, a};
        endcase
    endfunction

    logic [31:0] phys_mem [0:63];
    logic        phys_wr  [0:63] = '{default: 1'b0};
    logic        rv_a [0:7] = '{default: 1'b0};
    logic        rv_b [0:7] = '{default: 1'b0};
    logic [5:0]  ra_a [0:7] = '{default: 6'd0};
    logic [5:0]  ra_b [0:7] = '{default: 6'd0};
    int          cyc = 0;
    int          wr_cnt = 0;

    function automatic logic [31:0] phys_rd(input logic [5:0] a);
        return phys_wr[a] ? phys_mem[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rv_a[0] <= (if_a.mem_cmd == 2'b01);
        ra_a[0] <= if_a.mem_addr[5:0];
        rv_b[0] <= (if_b.mem_cmd == 2'b01);
        ra_b[0] <= if_b.mem_addr[5:0];
        for (int i = 1; i < 8; i++) begin
            rv_a[i] <= rv_a[i-1];
            ra_a[i] <= ra_a[i-1];
            rv_b[i] <= rv_b[i-1];
            ra_b[i] <= ra_b[i-1];
        end
        if (if_a.mem_cmd == 2'b10) begin
            phys_mem[if_a.mem_addr[5:0]] <= if_a.mem_wr_data;
            phys_wr[if_a.mem_addr[5:0]]  <= 1'b1;
        end
        if (if_b.mem_cmd == 2'b10) begin
            phys_mem[if_b.mem_addr[5:0]] <= if_b.mem_wr_data;
            phys_wr[if_b.mem_addr[5:0]]  <= 1'b1;
        end
        if (if_a.mem_cmd == 2'b10 || if_b.mem_cmd == 2'b10) wr_cnt <= wr_cnt + 1;
    end

    assign if_a.mem_rd_data = rv_a[0] ? phys_rd(ra_a[0]) : {16'hBAD0, cyc[15:0]};
    assign if_b.mem_rd_data = rv_b[2] ? phys_rd(ra_b[2]) : {16'hBAD1, cyc[15:0]};

    // Model: each accepted request expands into its expected per-cycle output trace.
    typedef struct packed {
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [NP-1:0] done;
        logic [DW-1:0] rsp;
        logic [NP-1:0] grant;
        logic          commit;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] mdl_mem [0:63];
    logic        mdl_wr  [0:63] = '{default: 1'b0};
    int          mdl_last = NP - 1;
    bit          m_idle = 1'b1;
    bit          chk_en = 1'b0;
    logic [5:0]  pw_a;
    logic [31:0] pw_d;
    int          lat_cnt = 0;
    int          done_lat = 0;
    logic [31:0] done_rsp = '0;
    logic [NP-1:0] done_port = '0;
    logic [NP-1:0] seen_done = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdl_rd(input logic [5:0] a);
        return mdl_wr[a] ? mdl_mem[a] : init_word(a);
    endfunction

    function automatic exp_t mk(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [NP-1:0] d, input logic [DW-1:0] r, input logic [NP-1:0] g,
                                input logic cm);
        exp_t e;
        e.cmd = c; e.addr = a; e.wd = wd; e.done = d; e.rsp = r; e.grant = g; e.commit = cm;
        return e;
    endfunction

    task automatic schedule();
        int win, lat, p;
        bit rr;
        logic [1:0] c;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, old, mg;
        logic [BW-1:0] be;
        logic [NP-1:0] g;
        win = -1;
        rr  = (sel == 1'b0);
        lat = sel ? 3 : 1;
        for (int k = 0; k < NP; k++) begin
            p = rr ? (mdl_last + 1 + k) % NP : k;
            if (win < 0 && (t_cmd[2*p +: 2] == 2'b01 || t_cmd[2*p +: 2] == 2'b10)) win = p;
        end
        if (win < 0) return;
        c  = t_cmd[2*win +: 2];
        a  = t_addr[AW*win +: AW];
        wd = t_wdata[DW*win +: DW];
        be = t_be[BW*win +: BW];
        g  = '0;
        g[win] = 1'b1;
        old = mdl_rd(a[5:0]);
        for (int b = 0; b < BW; b++) mg[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
        mdl_last = win;
        lat_cnt  = 0;
        if (c == 2'b01) begin
            exp_q.push_back(mk(2'b01, a, '0, '0, '0, g, 1'b0));
            for (int i = 0; i < lat; i++) exp_q.push_back(mk(2'b00, a, '0, '0, '0, g, 1'b0));
            exp_q.push_back(mk(2'b00, '0, '0, g, old, g, 1'b0));
        end else if (be == '0) begin
            exp_q.push_back(mk(2'b00, '0, '0, g, '0, g, 1'b0));
        end else if (&be) begin
            pw_a = a[5:0]; pw_d = wd;
            exp_q.push_back(mk(2'b10, a, wd, '0, '0, g, 1'b0));
            exp_q.push_back(mk(2'b00, '0, '0, g, '0, g, 1'b1));
        end else begin
            pw_a = a[5:0]; pw_d = mg;
            exp_q.push_back(mk(2'b01, a, '0, '0, '0, g, 1'b0));
            for (int i = 0; i < lat; i++) exp_q.push_back(mk(2'b00, a, '0, '0, '0, g, 1'b0));
            exp_q.push_back(mk(2'b10, a, mg, '0, '0, g, 1'b0));
            exp_q.push_back(mk(2'b00, '0, '0, g, '0, g, 1'b1));
        end
    endtask

    // One cycle: advance model over the edge just taken, compare, then act as requester on done.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        seen_done = '0;
        if (!chk_en) return;
        if (m_idle) schedule();
        if (exp_q.size() == 0) begin
            e = '0;
            m_idle = 1'b1;
        end else begin
            e = exp_q.pop_front();
            m_idle = 1'b0;
        end
        lat_cnt++;
        chk("mem_cmd",     64'(o_cmd),   64'(e.cmd));
        chk("mem_addr",    64'(o_addr),  64'(e.addr));
        chk("mem_wr_data", 64'(o_wd),    64'(e.wd));
        chk("done",        64'(o_done),  64'(e.done));
        chk("rsp_rdata",   64'(o_rsp),   64'(e.rsp));
        chk("grant",       64'(o_grant), 64'(e.grant));
        if (e.commit) begin
            mdl_mem[pw_a] = pw_d;
            mdl_wr[pw_a]  = 1'b1;
        end
        seen_done = o_done;
        if (o_done != '0) begin
            done_lat  = lat_cnt;
            done_rsp  = o_rsp;
            done_port = o_done;
            for (int p = 0; p < NP; p++) if (o_done[p]) t_cmd[2*p +: 2] = 2'b00;
        end
    endtask

    task automatic set_req(input int p, input logic [1:0] c, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [BW-1:0] be);
        t_cmd[2*p +: 2]     = c;
        t_addr[AW*p +: AW]  = a;
        t_wdata[DW*p +: DW] = wd;
        t_be[BW*p +: BW]    = be;
    endtask

    task automatic txn(input int p, input logic [1:0] c, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [BW-1:0] be);
        int n;
        set_req(p, c, a, wd, be);
        n = 0;
        do begin
            tick();
            n++;
        end while (seen_done == '0 && n < 40);
        chk("txn_completes", 64'(seen_done != '0), 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_mem_cmd"},  64'(o_cmd),   64'd0);
        chk({name, "_mem_addr"}, 64'(o_addr),  64'd0);
        chk({name, "_wr_data"},  64'(o_wd),    64'd0);
        chk({name, "_done"},     64'(o_done),  64'd0);
        chk({name, "_rsp"},      64'(o_rsp),   64'd0);
        chk({name, "_grant"},    64'(o_grant), 64'd0);
    endtask

    task automatic fairness(input int total, input int reassert_upto, output int order [0:7], output int nd);
        int n;
        nd = 0;
        n  = 0;
        while (nd < total && n < 200) begin
            tick();
            n++;
            if (seen_done != '0) begin
                order[nd] = seen_done[1] ? 1 : 0;
                nd++;
                if (nd <= reassert_upto) t_cmd[2*order[nd-1] +: 2] = 2'b01;
            end
        end
    endtask

    initial begin
        int order [0:7];
        int nd, wr_before;

        // Power-up reset
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;
        idle_cycles(2);

        // Partial write on port 1: 0x11223344 merged with byte 1 of 0xAABBCCDD
        txn(1, 2'b10, 17'h5, 32'hAABBCCDD, 4'b0010);
        chk("pw_latency", 64'(done_lat), 64'd4);
        chk("pw_port", 64'(done_port), 64'b10);
        idle_cycles(1);
        chk("pw_memory", 64'(phys_mem[5]), 64'h1122CC44);

        // Reset in the middle of RD_WAIT of a partial write abandons it
        set_req(0, 2'b10, 17'h7, 32'h000000EE, 4'b0001);
        for (int i = 0; i < 10 && lat_cnt != 2; i++) tick();
        wr_before = wr_cnt;
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_mid");
        chk_en = 1'b0;
        t_cmd  = '0;
        exp_q.delete();
        m_idle   = 1'b1;
        mdl_last = NP - 1;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;
        idle_cycles(4);
        chk("no_write_after_reset", 64'(wr_cnt), 64'(wr_before));
        chk("addr7_untouched", 64'(phys_wr[7]), 64'd0);

        // Port 0 read after reset
        txn(0, 2'b01, 17'h10, '0, '0);
        chk("rd_latency", 64'(done_lat), 64'd3);
        chk("rd_data", 64'(done_rsp), 64'hDEADBEEF);

        // Full write then read back
        txn(0, 2'b10, 17'h8, 32'h55667788, 4'b1111);
        chk("fw_latency", 64'(done_lat), 64'd2);
        txn(0, 2'b01, 17'h8, '0, '0);
        chk("fw_readback", 64'(done_rsp), 64'h55667788);

        // Empty byte-enable write touches no memory
        txn(1, 2'b10, 17'h9, 32'h12345678, 4'b0000);
        chk("ew_latency", 64'(done_lat), 64'd1);
        idle_cycles(2);
        chk("ew_no_write", 64'(phys_wr[9]), 64'd0);

        // Illegal command is ignored
        set_req(0, 2'b11, 17'h3, '0, '0);
        idle_cycles(6);
        t_cmd = '0;
        idle_cycles(1);

        // Round-robin: both ports keep requesting reads
        set_req(0, 2'b01, 17'h20, '0, '0);
        set_req(1, 2'b01, 17'h21, '0, '0);
        fairness(5, 3, order, nd);
        chk("rr_count", 64'(nd), 64'd5);
        chk("rr_order", {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0], order[4][7:0]},
            64'h0001000100);
        idle_cycles(2);

        // Switch to RD_LAT=3, fixed-priority instance
        sel = 1'b1;
        idle_cycles(2);
        txn(0, 2'b01, 17'h10, '0, '0);
        chk("lat3_rd_latency", 64'(done_lat), 64'd5);
        chk("lat3_rd_data", 64'(done_rsp), 64'hDEADBEEF);
        txn(1, 2'b10, 17'h5, 32'h99000000, 4'b1000);
        chk("lat3_pw_latency", 64'(done_lat), 64'd6);
        idle_cycles(1);
        chk("lat3_pw_memory", 64'(phys_mem[5]), 64'h9922CC44);

        set_req(0, 2'b01, 17'h20, '0, '0);
        set_req(1, 2'b01, 17'h21, '0, '0);
        fairness(4, 2, order, nd);
        chk("fixed_count", 64'(nd), 64'd4);
        chk("fixed_order", {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0]},
            64'h00000001);
        idle_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
